// File: rtl/lpm_ram_2port_if.sv
// lpm_ram_2port_if: write/read request bundle and read-result signals for lpm_ram_2port
interface lpm_ram_2port_if #(
    parameter int LPM_WIDTH      = 32,
    parameter int LPM_WIDTHAD    = 8,
    parameter int LPM_BYTE_WIDTH = 8
);
    localparam int NB = LPM_WIDTH / LPM_BYTE_WIDTH;
    logic                   wren;
    logic [LPM_WIDTHAD-1:0] wraddress;
    logic [LPM_WIDTH-1:0]   data;
    logic [NB-1:0]          byteena;
    logic                   rden;
    logic [LPM_WIDTHAD-1:0] rdaddress;
    logic [LPM_WIDTH-1:0]   q;
    logic                   q_valid;
    logic                   addr_err;
    modport master (
        output wren, wraddress, data, byteena, rden, rdaddress,
        input  q, q_valid, addr_err
    );
    modport slave (
        input  wren, wraddress, data, byteena, rden, rdaddress,
        output q, q_valid, addr_err
    );
endinterface

// File: rtl/lpm_ram_2port.sv
// lpm_ram_2port: byte-enabled simple dual-port RAM with pipelined, range-checked reads
module lpm_ram_2port #(
  parameter int    LPM_WIDTH      = 32,
  parameter int    LPM_WIDTHAD    = 8,
  parameter int    LPM_NUMWORDS   = 1 << LPM_WIDTHAD,
  parameter int    LPM_BYTE_WIDTH = 8,
  parameter string LPM_OUTDATA    = "REGISTERED",
  parameter string LPM_RDW_MODE   = "OLD_DATA",
  parameter string LPM_FILE       = "UNUSED"
) (
  input logic            clock,
  input logic            aclr_n,
  lpm_ram_2port_if.slave bus
);
  localparam bit PARAMS_OK = LPM_WIDTH >= 1 && LPM_WIDTHAD >= 1 && LPM_BYTE_WIDTH >= 1
    && (LPM_WIDTH % LPM_BYTE_WIDTH) == 0
    && LPM_NUMWORDS > (1 << (LPM_WIDTHAD - 1)) && LPM_NUMWORDS <= (1 << LPM_WIDTHAD)
    && (LPM_OUTDATA == "REGISTERED" || LPM_OUTDATA == "UNREGISTERED")
    && (LPM_RDW_MODE == "OLD_DATA" || LPM_RDW_MODE == "NEW_DATA");
  localparam int NB = LPM_WIDTH / LPM_BYTE_WIDTH;
  localparam int LAT = (LPM_OUTDATA == "REGISTERED") ? 2 : 1;
  localparam bit NEW_DATA = (LPM_RDW_MODE == "NEW_DATA");
  localparam logic [LPM_WIDTHAD:0] DEPTH = (LPM_WIDTHAD + 1)'(LPM_NUMWORDS);
  if (!PARAMS_OK) begin : g_bad_params
    $fatal(1, "lpm_ram_2port: invalid parameter combination");
  end
  logic [LPM_WIDTH-1:0] mem [LPM_NUMWORDS];
  logic [LPM_WIDTH-1:0] merged;
  logic [LPM_WIDTH-1:0] rd_word;
  logic [LPM_WIDTH-1:0] pd [LAT];
  logic [LAT-1:0]       pv;
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 wr_go;
  assign wr_ok = ({1'b0, bus.wraddress} < DEPTH) === 1'b1;
  assign rd_ok = ({1'b0, bus.rdaddress} < DEPTH) === 1'b1;
  assign wr_go = bus.wren && wr_ok;
  initial begin
    for (int i = 0; i < LPM_NUMWORDS; i++) mem[i] = '0;
  end
  always_comb begin
    merged = mem[bus.wraddress];
    for (int k = 0; k < NB; k++)
      if (bus.byteena[k]) merged[k*LPM_BYTE_WIDTH +: LPM_BYTE_WIDTH] = bus.data[k*LPM_BYTE_WIDTH +: LPM_BYTE_WIDTH];
  end
  always_comb begin
    rd_word = !rd_ok ? '0
            : (NEW_DATA && wr_go && bus.rdaddress == bus.wraddress) ? merged
            : mem[bus.rdaddress];
  end
  always_ff @(posedge clock)
    if (aclr_n && wr_go) mem[bus.wraddress] <= merged;
  always_ff @(posedge clock or negedge aclr_n)
    if (!aclr_n) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pd[i] <= '0;
      bus.q <= '0;
      bus.q_valid <= 1'b0;
      bus.addr_err <= 1'b0;
    end else begin
      pv[0] <= bus.rden;
      if (bus.rden) pd[0] <= rd_word;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
      bus.q_valid <= pv[LAT-1];
      if (pv[LAT-1]) bus.q <= pd[LAT-1];
      bus.addr_err <= (bus.wren && !wr_ok) || (bus.rden && !rd_ok);
    end
endmodule

// File: tb/tb_lpm_ram_2port.sv
// tb_lpm_ram_2port: directed checks of a REGISTERED/OLD_DATA depth-12 RAM and an UNREGISTERED/NEW_DATA depth-16 RAM
module tb_lpm_ram_2port;
    logic clock = 1'b0;
    logic aclr_n = 1'b1;
    logic wren, rden;
    logic [3:0] wraddress, rdaddress, byteena;
    logic [31:0] data;
    int vectors = 0;
    int miscompares = 0;

    lpm_ram_2port_if #(.LPM_WIDTH(32), .LPM_WIDTHAD(4), .LPM_BYTE_WIDTH(8)) ba ();
    lpm_ram_2port_if #(.LPM_WIDTH(32), .LPM_WIDTHAD(4), .LPM_BYTE_WIDTH(8)) bb ();

    assign ba.wren = wren;
    assign ba.wraddress = wraddress;
    assign ba.data = data;
    assign ba.byteena = byteena;
    assign ba.rden = rden;
    assign ba.rdaddress = rdaddress;
    assign bb.wren = wren;
    assign bb.wraddress = wraddress;
    assign bb.data = data;
    assign bb.byteena = byteena;
    assign bb.rden = rden;
    assign bb.rdaddress = rdaddress;

    lpm_ram_2port #(
        .LPM_WIDTH(32), .LPM_WIDTHAD(4), .LPM_NUMWORDS(12), .LPM_BYTE_WIDTH(8),
        .LPM_OUTDATA("REGISTERED"), .LPM_RDW_MODE("OLD_DATA"), .LPM_FILE("UNUSED")
    ) dut_a (.clock(clock), .aclr_n(aclr_n), .bus(ba));

    lpm_ram_2port #(
        .LPM_WIDTH(32), .LPM_WIDTHAD(4), .LPM_NUMWORDS(16), .LPM_BYTE_WIDTH(8),
        .LPM_OUTDATA("UNREGISTERED"), .LPM_RDW_MODE("NEW_DATA"), .LPM_FILE("UNUSED")
    ) dut_b (.clock(clock), .aclr_n(aclr_n), .bus(bb));

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic [3:0] wa, input logic [31:0] d, input logic [3:0] be,
                         input logic r, input logic [3:0] ra);
        wren = w; wraddress = wa; data = d; byteena = be; rden = r; rdaddress = ra;
    endtask

    task automatic test_reset();
        drive(1'b1, 4'd0, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'd0);
        #2 aclr_n = 1'b0;
        #1;
        vectors++;
        if (ba.q !== 32'h0 || ba.q_valid !== 1'b0 || ba.addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_a: q=%h v=%b err=%b, want 0/0/0", ba.q, ba.q_valid, ba.addr_err);
        end
        vectors++;
        if (bb.q !== 32'h0 || bb.q_valid !== 1'b0 || bb.addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_b: q=%h v=%b err=%b, want 0/0/0", bb.q, bb.q_valid, bb.addr_err);
        end
        tick();
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        aclr_n = 1'b1;
        tick();
        vectors++;
        if (ba.q_valid !== 1'b0 || bb.q_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: a.v=%b b.v=%b, want 0/0", ba.q_valid, bb.q_valid);
        end
    endtask

    task automatic test_latency();
        drive(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF, 1'b0, 4'd0);
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3);
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        vectors++;
        if (ba.q_valid !== 1'b0 || bb.q_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_edge_n: a.v=%b b.v=%b, want 0/0", ba.q_valid, bb.q_valid);
        end
        tick();
        vectors++;
        if (bb.q_valid !== 1'b1 || bb.q !== 32'hDEAD_BEEF || ba.q_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_n1: b.q=%h b.v=%b a.v=%b, want deadbeef/1/0", bb.q, bb.q_valid, ba.q_valid);
        end
        tick();
        vectors++;
        if (ba.q_valid !== 1'b1 || ba.q !== 32'hDEAD_BEEF || bb.q_valid !== 1'b0 || bb.q !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL lat_n2: a.q=%h a.v=%b b.q=%h b.v=%b, want deadbeef/1 deadbeef/0",
                     ba.q, ba.q_valid, bb.q, bb.q_valid);
        end
        tick();
        vectors++;
        if (ba.q_valid !== 1'b0 || ba.q !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL lat_n3: a.q=%h a.v=%b, want deadbeef/0", ba.q, ba.q_valid);
        end
    endtask

    task automatic test_byte_lanes();
        drive(1'b1, 4'd5, 32'h1122_3344, 4'hF, 1'b0, 4'd0);
        tick();
        drive(1'b1, 4'd5, 32'hAABB_CCDD, 4'b0101, 1'b0, 4'd0);
        tick();
        drive(1'b1, 4'd5, 32'hFFFF_FFFF, 4'b0000, 1'b0, 4'd0);
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5);
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        tick();
        vectors++;
        if (bb.q_valid !== 1'b1 || bb.q !== 32'h11BB_33DD) begin
            miscompares++;
            $display("FAIL lanes_b: q=%h v=%b, want 11bb33dd/1", bb.q, bb.q_valid);
        end
        tick();
        vectors++;
        if (ba.q_valid !== 1'b1 || ba.q !== 32'h11BB_33DD) begin
            miscompares++;
            $display("FAIL lanes_a: q=%h v=%b, want 11bb33dd/1", ba.q, ba.q_valid);
        end
    endtask

    task automatic test_rdw();
        drive(1'b1, 4'd7, 32'h0000_0077, 4'hF, 1'b0, 4'd0);
        tick();
        drive(1'b1, 4'd7, 32'h0, 4'hF, 1'b1, 4'd7);
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        tick();
        vectors++;
        if (bb.q_valid !== 1'b1 || bb.q !== 32'h0) begin
            miscompares++;
            $display("FAIL rdw_new: q=%h v=%b, want 00000000/1", bb.q, bb.q_valid);
        end
        tick();
        vectors++;
        if (ba.q_valid !== 1'b1 || ba.q !== 32'h77) begin
            miscompares++;
            $display("FAIL rdw_old: q=%h v=%b, want 00000077/1", ba.q, ba.q_valid);
        end
        drive(1'b1, 4'd7, 32'hFFFF_FFFF, 4'b1000, 1'b1, 4'd7);
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        tick();
        vectors++;
        if (bb.q_valid !== 1'b1 || bb.q !== 32'hFF00_0000) begin
            miscompares++;
            $display("FAIL rdw_new_merge: q=%h v=%b, want ff000000/1", bb.q, bb.q_valid);
        end
        tick();
        vectors++;
        if (ba.q_valid !== 1'b1 || ba.q !== 32'h0) begin
            miscompares++;
            $display("FAIL rdw_old_after: q=%h v=%b, want 00000000/1", ba.q, ba.q_valid);
        end
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 4'd13, 32'h1313_1313, 4'hF, 1'b0, 4'd0);
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        vectors++;
        if (ba.addr_err !== 1'b1 || bb.addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_wr_err: a.err=%b b.err=%b, want 1/0", ba.addr_err, bb.addr_err);
        end
        tick();
        vectors++;
        if (ba.addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_wr_pulse: a.err=%b, want 0", ba.addr_err);
        end
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd13);
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        vectors++;
        if (ba.addr_err !== 1'b1 || bb.addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_rd_err: a.err=%b b.err=%b, want 1/0", ba.addr_err, bb.addr_err);
        end
        tick();
        vectors++;
        if (bb.q_valid !== 1'b1 || bb.q !== 32'h1313_1313 || ba.addr_err !== 1'b0 || ba.q_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_rd_n1: b.q=%h b.v=%b a.err=%b a.v=%b, want 13131313/1 0/0",
                     bb.q, bb.q_valid, ba.addr_err, ba.q_valid);
        end
        tick();
        vectors++;
        if (ba.q_valid !== 1'b1 || ba.q !== 32'h0) begin
            miscompares++;
            $display("FAIL oor_rd_q: q=%h v=%b, want 00000000/1", ba.q, ba.q_valid);
        end
        drive(1'b1, 4'd14, 32'h1, 4'hF, 1'b1, 4'd15);
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        vectors++;
        if (ba.addr_err !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_both_err: a.err=%b, want 1", ba.addr_err);
        end
        tick();
        vectors++;
        if (ba.addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_both_single: a.err=%b, want 0", ba.addr_err);
        end
    endtask

    task automatic test_back_to_back();
        bit          av [6] = '{0, 0, 1, 1, 1, 0};
        bit          bv [6] = '{0, 1, 1, 1, 0, 0};
        logic [31:0] aq [6] = '{32'h0, 32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222, 32'h0};
        logic [31:0] bq [6] = '{32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0};
        drive(1'b1, 4'd1, 32'h1111_1111, 4'hF, 1'b0, 4'd0);
        tick();
        drive(1'b1, 4'd2, 32'h2222_2222, 4'hF, 1'b0, 4'd0);
        tick();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(c));
            else drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
            tick();
            vectors++;
            if (ba.q_valid !== av[c] || (av[c] && ba.q !== aq[c])) begin
                miscompares++;
                $display("FAIL b2b_a cycle %0d: q=%h v=%b, want %h/%b", c, ba.q, ba.q_valid, aq[c], av[c]);
            end
            vectors++;
            if (bb.q_valid !== bv[c] || (bv[c] && bb.q !== bq[c])) begin
                miscompares++;
                $display("FAIL b2b_b cycle %0d: q=%h v=%b, want %h/%b", c, bb.q, bb.q_valid, bq[c], bv[c]);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd1);
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd2);
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd1);
        tick();
        vectors++;
        if (ba.q_valid !== 1'b1 || ba.q !== 32'h1111_1111) begin
            miscompares++;
            $display("FAIL mid_pre: a.q=%h a.v=%b, want 11111111/1", ba.q, ba.q_valid);
        end
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        aclr_n = 1'b0;
        #1;
        vectors++;
        if (ba.q !== 32'h0 || ba.q_valid !== 1'b0 || bb.q !== 32'h0 || bb.q_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: a=%h/%b b=%h/%b, want 0/0 0/0", ba.q, ba.q_valid, bb.q, bb.q_valid);
        end
        tick();
        aclr_n = 1'b1;
        tick();
        vectors++;
        if (ba.q_valid !== 1'b0 || bb.q_valid !== 1'b0 || ba.q !== 32'h0 || bb.q !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_flushed: a=%h/%b b=%h/%b, want 0/0 0/0", ba.q, ba.q_valid, bb.q, bb.q_valid);
        end
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd1);
        tick();
        drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        tick();
        vectors++;
        if (bb.q_valid !== 1'b1 || bb.q !== 32'h1111_1111) begin
            miscompares++;
            $display("FAIL mid_after_b: q=%h v=%b, want 11111111/1", bb.q, bb.q_valid);
        end
        tick();
        vectors++;
        if (ba.q_valid !== 1'b1 || ba.q !== 32'h1111_1111) begin
            miscompares++;
            $display("FAIL mid_after_a: q=%h v=%b, want 11111111/1", ba.q, ba.q_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_latency();
        test_byte_lanes();
        test_rdw();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
